// File: rtl/led_shift_out.sv
// -----------------------------------------------------------------------------
// led_shift_out
//
// Serialises the LED byte from the free-running counter stage into an external
// 74HC595-style shift/storage register, so that 8 LEDs need only 3 board pins.
// A transfer starts when DIN differs from the last byte sent, and once after
// reset so that the external register starts from a known state. DIN changes
// during a transfer are not queued: on return to IDLE only the latest value is
// compared and sent, because the LEDs show state, not history.
//
// Parameters:
//   CLK_DIV      system clocks per SCLK half-period (>= 1)
//   LATCH_CYCLES system clocks RCLK is held high (>= 1)
//   MSB_FIRST    1: DIN[7] is shifted first, 0: DIN[0] is shifted first
//   INIT_XFER    1: force one transfer after reset even when DIN == 0
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST    in   asynchronous active-high reset
//   DIN    in   [7:0] LED byte, sampled only in IDLE
//   SCLK   out  shift clock to the external register (registered)
//   SDATA  out  serial data (registered), stable around every SCLK rise
//   RCLK   out  storage latch strobe (registered)
//   BUSY   out  high from the capture edge until the transfer completes
//   DONE   out  one-cycle pulse when the latch phase completes
// -----------------------------------------------------------------------------
module led_shift_out #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned LATCH_CYCLES = 2,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter bit          INIT_XFER    = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DIN,
  output logic       SCLK,
  output logic       SDATA,
  output logic       RCLK,
  output logic       BUSY,
  output logic       DONE
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH
  } state_e;

  state_e           state_q,  state_d;
  logic [7:0]       shadow_q, shadow_d;   // last byte sent to the LEDs
  logic [7:0]       sreg_q,   sreg_d;     // bits still to be sent
  logic [2:0]       bit_q,    bit_d;      // index of the bit on SDATA
  logic [DIV_W-1:0] div_q,    div_d;      // cycles within an SCLK half-period
  logic [LAT_W-1:0] lat_q,    lat_d;      // cycles RCLK has been high
  logic             init_q,   init_d;     // forced transfer still owed
  logic             sclk_q,   sclk_d;
  logic             sdata_q,  sdata_d;
  logic             rclk_q,   rclk_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  // Bit that goes out first for a given register content.
  function automatic logic head_bit(input logic [7:0] v);
    return MSB_FIRST ? v[7] : v[0];
  endfunction

  logic [7:0] sreg_next;
  assign sreg_next = MSB_FIRST ? {sreg_q[6:0], 1'b0} : {1'b0, sreg_q[7:1]};

  // NOTE: every combinational output gets its hold value first, so no path
  // through the case statement leaves a signal unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    sreg_d   = sreg_q;
    bit_d    = bit_q;
    div_d    = div_q;
    lat_d    = lat_q;
    init_d   = init_q;
    sclk_d   = sclk_q;
    sdata_d  = sdata_q;
    rclk_d   = rclk_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if ((DIN != shadow_q) || init_q) begin
          shadow_d = DIN;
          sreg_d   = DIN;
          init_d   = 1'b0;
          busy_d   = 1'b1;
          sdata_d  = head_bit(DIN);
          sclk_d   = 1'b0;
          div_d    = '0;
          bit_d    = '0;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling SCLK edge: the external register has taken the bit, so
            // the next bit is presented now and stays put for a full period.
            sclk_d = 1'b0;
            if (bit_q == 3'd7) begin
              rclk_d  = 1'b1;
              lat_d   = '0;
              state_d = S_LATCH;
            end else begin
              bit_d   = bit_q + 1'b1;
              sreg_d  = sreg_next;
              sdata_d = head_bit(sreg_next);
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_LATCH: begin
        if (lat_q == LAT_LAST) begin
          rclk_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      shadow_q <= 8'h00;
      sreg_q   <= 8'h00;
      bit_q    <= '0;
      div_q    <= '0;
      lat_q    <= '0;
      init_q   <= INIT_XFER;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      rclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      sreg_q   <= sreg_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      lat_q    <= lat_d;
      init_q   <= init_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      rclk_q   <= rclk_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign SCLK  = sclk_q;
  assign SDATA = sdata_q;
  assign RCLK  = rclk_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_led_shift_out.sv
// -----------------------------------------------------------------------------
// Testbench for led_shift_out. Three instances share clock and reset:
//   k=0: CLK_DIV=1, LATCH_CYCLES=2, MSB first
//   k=1: CLK_DIV=4, LATCH_CYCLES=2, MSB first
//   k=2: CLK_DIV=1, LATCH_CYCLES=2, LSB first
// Each instance drives a behavioural 74HC595 model (shift on SCLK rise, latch
// on RCLK rise) sampled on the falling system clock edge. Inputs change 1 time
// unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_led_shift_out;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din   [3];
  logic       sclk  [3];
  logic       sdata [3];
  logic       rclk  [3];
  logic       busy  [3];
  logic       done  [3];

  always #5 clk = ~clk;

  led_shift_out #(.CLK_DIV(1), .LATCH_CYCLES(2), .MSB_FIRST(1'b1), .INIT_XFER(1'b1)) dut_a (
    .CLK(clk), .RST(rst), .DIN(din[0]), .SCLK(sclk[0]), .SDATA(sdata[0]),
    .RCLK(rclk[0]), .BUSY(busy[0]), .DONE(done[0]));

  led_shift_out #(.CLK_DIV(4), .LATCH_CYCLES(2), .MSB_FIRST(1'b1), .INIT_XFER(1'b1)) dut_b (
    .CLK(clk), .RST(rst), .DIN(din[1]), .SCLK(sclk[1]), .SDATA(sdata[1]),
    .RCLK(rclk[1]), .BUSY(busy[1]), .DONE(done[1]));

  led_shift_out #(.CLK_DIV(1), .LATCH_CYCLES(2), .MSB_FIRST(1'b0), .INIT_XFER(1'b1)) dut_c (
    .CLK(clk), .RST(rst), .DIN(din[2]), .SCLK(sclk[2]), .SDATA(sdata[2]),
    .RCLK(rclk[2]), .BUSY(busy[2]), .DONE(done[2]));

  // ---------------------------------------------------------------------------
  // Monitors and external register models
  // ---------------------------------------------------------------------------
  int         cyc = 0;
  logic       p_sclk [3], p_rclk [3], p_busy [3], p_done [3], p_sdata [3];
  logic [7:0] din_q  [3];                 // DIN as seen at the last rising edge
  logic [7:0] sr     [3];                 // external shift stage
  logic [7:0] q      [3];                 // external storage stage
  logic [7:0] prev_q [3];
  logic [7:0] seq    [3];                 // SDATA at each SCLK rise, first bit at MSB
  logic [7:0] cap_din [3];
  int rises [3], rclk_pulses [3], done_pulses [3], hi_cnt [3];
  int cap_cyc [3], lat [3], rclk_off [3], rclk_run [3], rclk_len [3];
  int lat_err [3], b2b [3], done_wo_rclk [3], sdata_bad [3], overlap [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      din[k] = 8'h00;     p_sclk[k] = 1'b0; p_rclk[k] = 1'b0; p_busy[k] = 1'b0;
      p_done[k] = 1'b0;   p_sdata[k] = 1'b0; din_q[k] = 8'h00;
      sr[k] = 8'hEE;      q[k] = 8'hEE;     prev_q[k] = 8'hEE; seq[k] = 8'hEE;
      cap_din[k] = 8'h00; rises[k] = 0;     rclk_pulses[k] = 0; done_pulses[k] = 0;
      hi_cnt[k] = 0;      cap_cyc[k] = 0;   lat[k] = 0;       rclk_off[k] = 0;
      rclk_run[k] = 0;    rclk_len[k] = 0;  lat_err[k] = 0;   b2b[k] = 0;
      done_wo_rclk[k] = 0; sdata_bad[k] = 0; overlap[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) din_q[k] <= din[k];
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) begin
      p_sclk[k]  <= sclk[k];
      p_rclk[k]  <= rclk[k];
      p_busy[k]  <= busy[k];
      p_done[k]  <= done[k];
      p_sdata[k] <= sdata[k];
      if (sclk[k]) hi_cnt[k] <= hi_cnt[k] + 1;
      if (sclk[k] && rclk[k]) overlap[k] <= overlap[k] + 1;
      if (sclk[k] && (sdata[k] != p_sdata[k])) sdata_bad[k] <= sdata_bad[k] + 1;
      if (sclk[k] && !p_sclk[k]) begin
        rises[k] <= rises[k] + 1;
        seq[k]   <= {seq[k][6:0], sdata[k]};
        sr[k]    <= (k == 2) ? {sdata[k], sr[k][7:1]} : {sr[k][6:0], sdata[k]};
      end
      if (rclk[k] && !p_rclk[k]) begin
        rclk_pulses[k] <= rclk_pulses[k] + 1;
        prev_q[k]      <= q[k];
        q[k]           <= sr[k];
        rclk_off[k]    <= cyc - cap_cyc[k];
        if (sr[k] != cap_din[k]) lat_err[k] <= lat_err[k] + 1;
      end
      if (rclk[k]) begin
        rclk_run[k] <= rclk_run[k] + 1;
      end else if (p_rclk[k]) begin
        rclk_len[k] <= rclk_run[k];
        rclk_run[k] <= 0;
      end
      if (busy[k] && !p_busy[k]) begin
        cap_cyc[k] <= cyc;
        cap_din[k] <= din_q[k];
        if (p_done[k]) b2b[k] <= b2b[k] + 1;
      end
      if (done[k] && !p_done[k]) begin
        done_pulses[k] <= done_pulses[k] + 1;
        lat[k]         <= cyc - cap_cyc[k];
        if (rclk_pulses[k] == done_pulses[k]) done_wo_rclk[k] <= done_wo_rclk[k] + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_done(input int k, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = done[k];
    end
    check({name, " done seen"}, 32'(seen), 1);
    #1;
  endtask

  task automatic wait_idle(input int k, input string name);
    logic idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      idle = !busy[k];
    end
    check({name, " idle"}, 32'(idle), 1);
    #1;
  endtask

  task automatic drive(input int k, input logic [7:0] v);
    @(posedge clk);
    #1 din[k] = v;
  endtask

  function automatic logic [4:0] outs(input int k);
    return {sclk[k], sdata[k], rclk[k], busy[k], done[k]};
  endfunction

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_q;
    int         exp_pulses;
  } vec_t;

  vec_t vecs [6];

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int r0, h0, p0, b0;
    logic got;

    vecs[0] = '{din: 8'hFF, exp_q: 8'hFF, exp_pulses: 1};
    vecs[1] = '{din: 8'h80, exp_q: 8'h80, exp_pulses: 1};
    vecs[2] = '{din: 8'h80, exp_q: 8'h80, exp_pulses: 0};
    vecs[3] = '{din: 8'h7E, exp_q: 8'h7E, exp_pulses: 1};
    vecs[4] = '{din: 8'h00, exp_q: 8'h00, exp_pulses: 1};
    vecs[5] = '{din: 8'h00, exp_q: 8'h00, exp_pulses: 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("reset outs k%0d", k), 32'(outs(k)), 0);

    // 1: forced transfer of 8'h00 after reset, CLK_DIV=1
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t1 busy before capture", 32'(busy[0]), 0);
    @(negedge clk);
    check("t1 busy after capture", 32'(busy[0]), 1);
    wait_done(0, "t1");
    check("t1 latency", lat[0], 18);
    check("t1 rclk offset", rclk_off[0], 16);
    check("t1 rclk length", rclk_len[0], 2);
    check("t1 sclk rises", rises[0], 8);
    check("t1 sdata bits", 32'(seq[0]), 32'h00);
    check("t1 latched", 32'(q[0]), 32'h00);
    repeat (30) @(negedge clk);
    #1;
    check("t1 quiet rises", rises[0], 8);
    check("t1 quiet busy", 32'(busy[0]), 0);

    // Table-driven vectors on instance 0
    for (int v = 0; v < 6; v++) begin
      p0 = rclk_pulses[0];
      drive(0, vecs[v].din);
      if (vecs[v].exp_pulses != 0) begin
        wait_done(0, $sformatf("vec%0d", v));
        check($sformatf("vec%0d latency", v), lat[0], 18);
      end else begin
        repeat (25) @(negedge clk);
      end
      repeat (2) @(negedge clk);
      #1;
      check($sformatf("vec%0d latched", v), 32'(q[0]), 32'(vecs[v].exp_q));
      check($sformatf("vec%0d pulses", v), rclk_pulses[0] - p0, vecs[v].exp_pulses);
    end

    // 2: 8'h00 -> 8'hA5 at CLK_DIV=4
    wait_idle(1, "t2 init");
    r0 = rises[1];
    h0 = hi_cnt[1];
    drive(1, 8'hA5);
    wait_done(1, "t2");
    check("t2 latency", lat[1], 66);
    check("t2 sdata bits", 32'(seq[1]), 32'hA5);
    check("t2 latched", 32'(q[1]), 32'hA5);
    check("t2 sclk rises", rises[1] - r0, 8);
    check("t2 sclk high cycles", hi_cnt[1] - h0, 32);
    check("t2 rclk offset", rclk_off[1], 64);

    // 3: LSB first, 8'h01
    wait_idle(2, "t3 init");
    drive(2, 8'h01);
    wait_done(2, "t3");
    check("t3 sdata bits", 32'(seq[2]), 32'h80);
    check("t3 latched", 32'(q[2]), 32'h01);
    check("t3 latency", lat[2], 18);

    // 4: DIN changes during a transfer; only the latest value follows
    p0 = rclk_pulses[0];
    b0 = b2b[0];
    drive(0, 8'h01);
    repeat (4) @(posedge clk);
    #1 din[0] = 8'h02;
    repeat (4) @(posedge clk);
    #1 din[0] = 8'h03;
    @(negedge clk);
    check("t4 still busy", 32'(busy[0]), 1);
    wait_done(0, "t4 first");
    wait_done(0, "t4 second");
    repeat (20) @(negedge clk);
    #1;
    check("t4 pulses", rclk_pulses[0] - p0, 2);
    check("t4 first byte", 32'(prev_q[0]), 32'h01);
    check("t4 final byte", 32'(q[0]), 32'h03);
    check("t4 back-to-back", b2b[0] - b0, 1);

    // 5: counter-driven DIN, one step every 10 cycles
    b0 = b2b[0];
    p0 = lat_err[0];
    for (int i = 0; i < 8; i++) begin
      drive(0, 8'h10 + 8'(i));
      repeat (9) @(posedge clk);
    end
    wait_done(0, "t5");
    repeat (5) @(negedge clk);
    #1;
    check("t5 final byte", 32'(q[0]), 32'h17);
    check("t5 latched==captured", lat_err[0] - p0, 0);
    got = (b2b[0] - b0) >= 3;
    check("t5 back-to-back >=3", 32'(got), 1);

    // 6: reset during bit 4 of a CLK_DIV=4 transfer
    wait_idle(1, "t6 pre");
    r0 = rises[1];
    drive(1, 8'h3C);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = (rises[1] - r0) >= 4;
    end
    check("t6 reached bit 4", 32'(got), 1);
    p0 = rclk_pulses[1];
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6 async outs", 32'(outs(1)), 0);
    repeat (3) @(posedge clk);
    #1;
    check("t6 no aborted latch", rclk_pulses[1] - p0, 0);
    rst = 1'b0;
    wait_done(1, "t6");
    #1;
    check("t6 latched", 32'(q[1]), 32'h3C);
    check("t6 pulses", rclk_pulses[1] - p0, 1);
    check("t6 latency", lat[1], 66);

    // Global properties over the whole run
    repeat (100) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("k%0d sclk/rclk overlap", k), overlap[k], 0);
      check($sformatf("k%0d sdata moved while sclk high", k), sdata_bad[k], 0);
      check($sformatf("k%0d done without rclk", k), done_wo_rclk[k], 0);
      check($sformatf("k%0d latched==captured", k), lat_err[k], 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_shift_out.md
Name: led_shift_out

Overview:
- Downstream stage of the free-running LED counter.
- Consumes the counter's 8-bit LED byte and drives an external 74HC595-style serial-in/parallel-out register (serial data, shift clock, storage latch).
- Transfers only when the byte changes, plus once after reset so the external register starts from a known state.
- Lets the board drive 8 LEDs over 3 pins.

Parameters:
CLK_DIV, 4, system clocks per SCLK half-period (legal >=1)
LATCH_CYCLES, 2, system clocks RCLK is held high (legal >=1)
MSB_FIRST, 1, 1 = shift DIN[7] first, 0 = DIN[0] first
INIT_XFER, 1, 1 = force one transfer after reset even if DIN==0

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  reset, asynchronous, active-high
DIN  input  8  LED byte from the counter stage; sampled only in IDLE
SCLK  output  1  shift clock to external register (registered)
SDATA  output  1  serial data (registered), stable while SCLK high
RCLK  output  1  storage latch strobe (registered)
BUSY  output  1  high from the capture edge until transfer completes
DONE  output  1  one-cycle pulse when the latch completes

Behaviour:
- Reset (async, while RST=1): SCLK=0, SDATA=0, RCLK=0, BUSY=0, DONE=0; state=IDLE; shadow=8'h00; shift reg=0; bit count=0; div count=0; init_pending=INIT_XFER. Assertion mid-transfer aborts at once (no partial latch); the transfer restarts after release if init_pending is set.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - Capture condition: (DIN != shadow) or init_pending.
  - At capture edge E0: shadow<=DIN, shift reg<=DIN, init_pending<=0, BUSY<=1, SDATA<=first bit, SCLK<=0, state<=SHIFT.
  - Otherwise hold outputs; DONE=0.
- SHIFT:
  - 8 bits, each 2*CLK_DIV cycles.
  - SCLK rises after edge E0+CLK_DIV*(2i+1) and falls after E0+CLK_DIV*(2i+2), i=0..7.
  - SDATA updates to the next bit on the same edge SCLK falls (i<7). Data is stable CLK_DIV cycles before and after each rising SCLK.
  - After the 8th falling edge (E0+16*CLK_DIV): RCLK<=1, state<=LATCH; SDATA holds the last bit.
- LATCH:
  - RCLK high for LATCH_CYCLES cycles.
  - At edge E0+16*CLK_DIV+LATCH_CYCLES: RCLK<=0, BUSY<=0, DONE<=1 (for exactly one cycle), state<=IDLE.
- Earliest next capture is the following edge. Back-to-back transfers therefore have a 1-cycle IDLE gap, in which DONE=1 and BUSY=0.
- Total capture-to-DONE: 16*CLK_DIV+LATCH_CYCLES cycles.
- DIN changes while BUSY=1 are ignored. On return to IDLE, DIN is compared to shadow, so only the latest value is sent. Intermediate values are dropped by design: the LED display shows state, not history.
- SCLK, RCLK and SDATA come straight from flops (glitch-free). SCLK and RCLK are never high simultaneously.
- Counters: div count 0..CLK_DIV-1, sized to fit; bit count 0..7, 3 bits; no arithmetic overflow is reachable.
- Bit order: MSB_FIRST=1 shifts left and sends bit 7 first. After 8 SCLK rises the external register holds DIN with its Q7 = DIN[7].

Test Plan:
1. Reset release, DIN=8'h00, INIT_XFER=1, CLK_DIV=1, LATCH_CYCLES=2 -> BUSY high after first edge; 8 SCLK pulses with SDATA=0; RCLK high 2 cycles starting 16 cycles after capture; DONE pulse at capture+18; then idle, no further activity.
2. DIN 8'h00->8'hA5, CLK_DIV=4 -> SDATA samples at SCLK rises = 1,0,1,0,0,1,0,1 (MSB first); SCLK high/low 4 cycles each; DONE at capture+66; external model reads 8'hA5.
3. MSB_FIRST=0, DIN=8'h01 -> first SDATA bit 1, remaining 7 bits 0; model (LSB-first wiring) reads 8'h01.
4. DIN changes 8'h01->8'h02->8'h03 while BUSY=1 -> no capture until DONE; exactly one follow-up transfer of 8'h03; 8'h02 is never sent.
5. Counter-driven: DIN increments every 10 cycles, CLK_DIV=1 -> transfers back-to-back with 1-cycle IDLE gap; every transfer's latched byte equals the DIN value at its capture edge; no DONE without a preceding RCLK.
6. RST asserted at bit 4 of a transfer -> all outputs 0 in the same cycle (async); after release, a full transfer of the current DIN occurs (INIT_XFER=1); no RCLK pulse for the aborted one.
